// File: rtl/button_event_if.sv
// Button event bus: debounced level and tick strobe in, event pulses out.
// The slave modport is the button_event side, master is the driver side.
// The release pulse is carried on btn_release because "release" is a
// reserved word.
interface button_event_if;
    logic btn_lvl;
    logic tick;
    logic press;
    logic btn_release;
    logic click;
    logic long_press;
    logic rpt;
    logic held;

    modport slave (
        input  btn_lvl,
        input  tick,
        output press,
        output btn_release,
        output click,
        output long_press,
        output rpt,
        output held
    );

    modport master (
        output btn_lvl,
        output tick,
        input  press,
        input  btn_release,
        input  click,
        input  long_press,
        input  rpt,
        input  held
    );
endinterface

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press / release / click /
// long-press / auto-repeat pulses, timed by an external tick strobe.
// All outputs are registered, so no input reaches an output combinationally.
// Optional feature: define BUTTON_EVENT_REPEAT_EN to enable auto-repeat pulses
// on rpt while the button is held past the long-press threshold. Without it
// rpt is tied low and the counter simply holds in the LONG state.
module button_event #(
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 4,
    parameter int CNT_W        = 8
) (
    input  logic         clk,
    input  logic         rst,
    button_event_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    // Terminal counts are compared against the counter value before the
    // increment, hence the minus one.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    // Parameter legality is checked at elaboration only.
    if ((LONG_TICKS < 1) || (longint'(LONG_TICKS) > (64'sd1 <<< CNT_W)) ||
        (REPEAT_TICKS < 1) || (longint'(REPEAT_TICKS) > (64'sd1 <<< CNT_W))) begin : g_bad_params
        $error("button_event: LONG_TICKS/REPEAT_TICKS outside 1..2^CNT_W");
    end

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic press_r;
    logic release_r;
    logic click_r;
    logic long_r;
    logic held_r;

    logic press_nxt_s;
    logic release_nxt_s;
    logic click_nxt_s;
    logic long_nxt_s;
    logic held_nxt_s;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_TICKS - 1);
    logic rpt_r;
    logic rpt_nxt_s;
`endif

    // State, counter and output pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            click_r   <= 1'b0;
            long_r    <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            click_r   <= click_nxt_s;
            long_r    <= long_nxt_s;
            held_r    <= held_nxt_s;
        end
    end

    // Next-state, counter and pulse decode; release always beats a tick.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        click_nxt_s   = 1'b0;
        long_nxt_s    = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        rpt_nxt_s     = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                // Ticks are ignored while idle.
                if (bus.btn_lvl) begin
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = CNT_ZERO;
                    press_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_PRESSED: begin
                if (!bus.btn_lvl) begin
                    state_nxt_s   = ST_IDLE;
                    cnt_nxt_s     = CNT_ZERO;
                    release_nxt_s = 1'b1;
                    click_nxt_s   = 1'b1;
                end else if (bus.tick) begin
                    if (cnt_r == LONG_LAST) begin
                        state_nxt_s = ST_LONG;
                        cnt_nxt_s   = CNT_ZERO;
                        long_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_LONG: begin
                // No click here: the hold already passed the long threshold.
                if (!bus.btn_lvl) begin
                    state_nxt_s   = ST_IDLE;
                    cnt_nxt_s     = CNT_ZERO;
                    release_nxt_s = 1'b1;
                end else if (bus.tick) begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (cnt_r == RPT_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
                        rpt_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
`else
                    cnt_nxt_s = cnt_r;
`endif
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        held_nxt_s = (state_nxt_s != ST_IDLE);
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    // Auto-repeat pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_r <= 1'b0;
        end else begin
            rpt_r <= rpt_nxt_s;
        end
    end

    assign bus.rpt = rpt_r;
`else
    assign bus.rpt = 1'b0;
`endif

    assign bus.press       = press_r;
    assign bus.btn_release = release_r;
    assign bus.click       = click_r;
    assign bus.long_press  = long_r;
    assign bus.held        = held_r;

endmodule

// File: tb/tb_button_event.sv
// Testbench for button_event: directed stimulus pushes hand-derived expected
// pulses (event vector plus clock cycle) into a queue; a monitor on the
// falling edge pops and compares whenever any pulse output is high.
module tb_button_event;

    localparam logic [4:0] EV_NONE      = 5'b00000;
    localparam logic [4:0] EV_PRESS     = 5'b10000;
    localparam logic [4:0] EV_REL_CLICK = 5'b01100;
    localparam logic [4:0] EV_REL       = 5'b01000;
    localparam logic [4:0] EV_LONG      = 5'b00010;
    localparam logic [4:0] EV_RPT       = 5'b00001;

    typedef struct {
        logic [4:0] vec;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    int   press_cnt;
    int   rel_cnt;
    exp_t exp_q[$];

    button_event_if bus ();

    button_event #(
        .LONG_TICKS   (8),
        .REPEAT_TICKS (4),
        .CNT_W        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Drive one clock cycle of inputs; ev is the pulse this cycle must cause.
    task automatic drive(input logic b, input logic t, input logic [4:0] ev);
        exp_t e;
        if (ev != EV_NONE) begin
            e.vec = ev;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        bus.btn_lvl = b;
        bus.tick    = t;
        @(posedge clk);
        #1;
    endtask

    // One tick period with the button held: three quiet cycles then the tick.
    task automatic hold_tick(input logic [4:0] ev);
        drive(1'b1, 1'b0, EV_NONE);
        drive(1'b1, 1'b0, EV_NONE);
        drive(1'b1, 1'b0, EV_NONE);
        drive(1'b1, 1'b1, ev);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, EV_NONE);
    endtask

    function automatic logic [5:0] outs();
        return {bus.press, bus.btn_release, bus.click, bus.long_press, bus.rpt, bus.held};
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [4:0] got;
        exp_t       e;
        got = {bus.press, bus.btn_release, bus.click, bus.long_press, bus.rpt};
        if (bus.press) press_cnt = press_cnt + 1;
        if (bus.btn_release) rel_cnt = rel_cnt + 1;
        if (got != EV_NONE) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse: got %b want none (cycle %0d)", got, cyc);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.vec || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL pulse: got %b at cycle %0d want %b at cycle %0d",
                             got, cyc, e.vec, e.cyc);
                end
            end
        end
    end

    initial begin
        int p0;
        int r0;
        cyc       = 0;
        errors    = 0;
        checks    = 0;
        press_cnt = 0;
        rel_cnt   = 0;
        rst         = 1'b0;
        bus.btn_lvl = 1'b0;
        bus.tick    = 1'b0;

        // Reset state.
        #12;
        check("reset_outputs", 32'(outs()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Short press: 3 ticks then release -> press, release+click.
        drive(1'b1, 1'b0, EV_PRESS);
        check("held_after_press", 32'(bus.held), 32'd1);
        for (int k = 1; k <= 3; k++) hold_tick(EV_NONE);
        drive(1'b0, 1'b0, EV_REL_CLICK);
        check("held_after_click", 32'(bus.held), 32'd0);
        idle(3);

        // Long press at the 8th tick, release without click.
        drive(1'b1, 1'b0, EV_PRESS);
        for (int k = 1; k <= 9; k++) hold_tick((k == 8) ? EV_LONG : EV_NONE);
        check("held_in_long", 32'(bus.held), 32'd1);
        drive(1'b0, 1'b0, EV_REL);
        check("held_after_long_rel", 32'(bus.held), 32'd0);
        idle(3);

        // 20-tick hold: long at 8, repeats at 12/16/20 only when enabled.
        drive(1'b1, 1'b0, EV_PRESS);
        for (int k = 1; k <= 20; k++) begin
`ifdef BUTTON_EVENT_REPEAT_EN
            hold_tick((k == 8) ? EV_LONG :
                      ((k == 12) || (k == 16) || (k == 20)) ? EV_RPT : EV_NONE);
`else
            hold_tick((k == 8) ? EV_LONG : EV_NONE);
`endif
        end
        drive(1'b0, 1'b0, EV_REL);
        idle(3);

        // Release coincides with the 8th tick: release wins, click, no long.
        drive(1'b1, 1'b0, EV_PRESS);
        for (int k = 1; k <= 7; k++) hold_tick(EV_NONE);
        drive(1'b1, 1'b0, EV_NONE);
        drive(1'b1, 1'b0, EV_NONE);
        drive(1'b1, 1'b0, EV_NONE);
        drive(1'b0, 1'b1, EV_REL_CLICK);
        idle(3);

        // Reset in LONG: outputs clear at once, no release; fresh press after.
        drive(1'b1, 1'b0, EV_PRESS);
        for (int k = 1; k <= 8; k++) hold_tick((k == 8) ? EV_LONG : EV_NONE);
        drive(1'b1, 1'b0, EV_NONE);
        check("held_before_rst", 32'(bus.held), 32'd1);
        rst = 1'b0;
        #1;
        check("outputs_in_rst", 32'(outs()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, EV_PRESS);
        check("held_after_rst_press", 32'(bus.held), 32'd1);
        drive(1'b0, 1'b0, EV_REL_CLICK);
        idle(3);

        // Toggle every cycle for 10 cycles: alternating press / release.
        p0 = press_cnt;
        r0 = rel_cnt;
        for (int i = 0; i < 10; i++) begin
            if ((i % 2) == 0) drive(1'b1, 1'b0, EV_PRESS);
            else              drive(1'b0, 1'b0, EV_REL_CLICK);
        end
        idle(3);
        check("toggle_press_count", 32'(press_cnt - p0), 32'd5);
        check("toggle_release_count", 32'(rel_cnt - r0), 32'd5);

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 8: number of tick strobes held before a long press; legal range 1..2^CNT_W.
REQ-002 SHALL have parameter REPEAT_TICKS, default 4: number of tick strobes between auto-repeat pulses; legal range 1..2^CNT_W.
REQ-003 SHALL have parameter CNT_W, default 8: width of the tick counter.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_lvl  input  1  debounced button level (1 = pressed), synchronous to clk.
REQ-007 SHALL have port tick  input  1  one-cycle timebase strobe from a prescaler.
REQ-008 SHALL have port press  output  1  one-cycle pulse on press.
REQ-009 SHALL have port release  output  1  one-cycle pulse on any release.
REQ-010 SHALL have port click  output  1  one-cycle pulse on a release that occurs before the long-press threshold.
REQ-011 SHALL have port long_press  output  1  one-cycle pulse when the long-press threshold is reached.
REQ-012 SHALL have port rpt  output  1  one-cycle auto-repeat pulse.
REQ-013 SHALL have port held  output  1  level, high while the FSM is not IDLE.

Function
REQ-014 SHALL register all outputs, with no combinational path from any input to any output.
REQ-015 SHALL implement FSM states IDLE, PRESSED and LONG, plus counter cnt[CNT_W-1:0].
REQ-016 IDLE: when btn_lvl=1 is sampled, SHALL go to PRESSED, clear cnt, and pulse press in the following cycle.
REQ-017 PRESSED: when btn_lvl=0 is sampled, SHALL go to IDLE and pulse both release and click in the same cycle.
REQ-018 PRESSED, btn_lvl=1, tick=1: SHALL increment cnt; when cnt==LONG_TICKS-1 it SHALL instead go to LONG, clear cnt, and pulse long_press.
REQ-019 LONG: when btn_lvl=0 is sampled, SHALL go to IDLE and pulse release only (no click).
REQ-020 LONG, btn_lvl=1, tick=1: SHALL increment cnt; when cnt==REPEAT_TICKS-1 it SHALL clear cnt and pulse rpt (subject to REQ-029).
REQ-021 SHALL ignore tick in IDLE; cnt SHALL hold when tick=0.
REQ-022 Release and tick sampled in the same cycle: release SHALL win; no long_press or rpt SHALL be issued.
REQ-023 A press sampled in the cycle of the release pulse SHALL start a new press normally, so back-to-back press/release at 1-cycle granularity produces alternating pulses.
REQ-024 Each output pulse SHALL be exactly one clk cycle; long_press SHALL fire at most once per hold.
REQ-025 held SHALL be 1 in PRESSED and LONG, and 0 in IDLE.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE, cnt=0, and all outputs (press, release, click, long_press, rpt, held) to 0.
REQ-027 Reset asserted mid-hold SHALL produce no release pulse; after reset deasserts with btn_lvl=1, REQ-016 SHALL apply and generate a fresh press.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge.

Configuration
REQ-029 With macro BUTTON_EVENT_REPEAT_EN defined, auto-repeat SHALL behave as in REQ-020; without it, rpt SHALL be tied to 0, cnt SHALL hold in LONG, and no repeat logic SHALL be synthesized.

Verification
REQ-030 Defaults, tick every 4 clks: btn_lvl high for 3 ticks, then low -> one press, one release and one click; no long_press.
REQ-031 btn_lvl held for 8 ticks -> long_press on the 8th tick; release on drop with click=0.
REQ-032 With REPEAT_EN, btn_lvl held for 20 ticks -> long_press at tick 8, rpt at ticks 12, 16 and 20; without REPEAT_EN -> rpt never asserts.
REQ-033 btn_lvl falls in the same cycle as the 8th tick -> release and click pulse; long_press stays 0.
REQ-034 rst pulled low during LONG -> all outputs 0 immediately; after rst high with btn_lvl=1 -> press one cycle later, held=1.
REQ-035 btn_lvl toggled every clk cycle for 10 cycles -> 5 press and 5 release pulses, never overlapping in the same cycle.
